// File: rtl/debug_pkg.sv
// Shared constants for the host side of the pipeline debug protocol:
// opcode bytes, default widths and the host-master state encoding.
package debug_pkg;

    localparam int N_DEF          = 8;
    localparam int DATA_SZ_DEF    = 32;
    localparam int CNT_W_DEF      = 8;
    localparam int BYTES_PER_WORD = DATA_SZ_DEF / N_DEF;

    localparam logic [7:0] OP_LOAD_INST = 8'h4C;
    localparam logic [7:0] OP_STEP      = 8'h53;
    localparam logic [7:0] OP_RUN       = 8'h43;
    localparam logic [7:0] OP_READ_REGS = 8'h52;
    localparam logic [7:0] OP_READ_MEM  = 8'h4D;
    localparam logic [7:0] OP_READ_PC   = 8'h50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_SEND_ARG,
        ST_RECV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/debug_word_packer.sv
// Packs RX bytes MSB-first into response words; resp_valid pulses one cycle after the
// last byte of a word, resp_data holds until the next word. No backpressure: one byte per push.
module debug_word_packer #(
    parameter int N       = 8,
    parameter int DATA_SZ = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic [N-1:0]       rx_byte,
    output logic               word_done,
    output logic [DATA_SZ-1:0] resp_data,
    output logic               resp_valid
);

    localparam int BPW   = DATA_SZ / N;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0]     byte_cnt;
    logic [DATA_SZ-N-1:0] word_q;
    logic [DATA_SZ-1:0]   shifted;

    // Only the low DATA_SZ-N bits need storing; the incoming byte completes the word.
    assign shifted   = {word_q, rx_byte};
    assign word_done = push && (byte_cnt == IDX_W'(BPW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            word_q     <= '0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= word_done;
            if (word_done)
                resp_data <= shifted;
            if (clear) begin
                byte_cnt <= '0;
                word_q   <= '0;
            end else if (push) begin
                word_q   <= shifted[DATA_SZ-N-1:0];
                byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_host_master.sv
// UART debug command initiator: op (+ MSB-first arg) to TX, nresp words from RX; no-arg/no-resp
// command completes two cycles after accept. Stalls on TX full / RX empty; RECV aborts after TIMEOUT idle cycles.
module debug_host_master
    import debug_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DATA_SZ = DATA_SZ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [N-1:0]       i_cmd_op,
    input  logic               i_cmd_has_arg,
    input  logic [DATA_SZ-1:0] i_cmd_arg,
    input  logic [CNT_W-1:0]   i_cmd_nresp,
    output logic [N-1:0]       o_tx_data,
    output logic               o_wr,
    input  logic               i_tx_full,
    input  logic [N-1:0]       i_rx_data,
    input  logic               i_rx_empty,
    output logic               o_rd,
    output logic [DATA_SZ-1:0] o_resp_data,
    output logic               o_resp_valid,
    output logic               o_done,
    output logic               o_timeout,
    output logic               o_busy
);

    localparam int BPW   = DATA_SZ / N;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state, state_nxt, after_send;
    logic [N-1:0]       op_q;
    logic               has_arg_q;
    logic [DATA_SZ-1:0] arg_q;
    logic [CNT_W-1:0]   nresp_q, word_cnt;
    logic [IDX_W-1:0]   byte_idx;
    logic [TO_W-1:0]    to_cnt;
    logic               in_recv, pop, word_done, all_words, to_hit;

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_busy      = !o_cmd_ready;
    assign in_recv     = (state == ST_RECV);
    assign pop         = in_recv && o_rd;
    assign all_words   = (word_cnt == nresp_q);
    assign to_hit      = (to_cnt == TO_W'(TIMEOUT - 1));
    assign after_send  = (nresp_q != '0) ? ST_RECV : ST_DONE;

    always_comb begin
        state_nxt = state;
        o_tx_data = op_q;
        o_wr      = 1'b0;
        o_rd      = 1'b0;
        o_done    = 1'b0;
        o_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                o_rd = !i_rx_empty;  // stray bytes are discarded
                if (i_cmd_valid)
                    state_nxt = ST_SEND_OP;
            end
            ST_SEND_OP: begin
                o_wr = !i_tx_full;
                if (!i_tx_full)
                    state_nxt = has_arg_q ? ST_SEND_ARG : after_send;
            end
            ST_SEND_ARG: begin
                o_tx_data = arg_q[DATA_SZ-1 -: N];
                o_wr      = !i_tx_full;
                if (!i_tx_full && byte_idx == IDX_W'(BPW - 1))
                    state_nxt = after_send;
            end
            ST_RECV: begin
                // all_words is seen in the o_resp_valid cycle of the final word
                if (all_words) begin
                    state_nxt = ST_DONE;
                end else if (to_hit) begin
                    o_timeout = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    o_rd = !i_rx_empty;
                end
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            op_q      <= '0;
            has_arg_q <= 1'b0;
            arg_q     <= '0;
            nresp_q   <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            to_cnt    <= '0;
        end else begin
            if (o_cmd_ready && i_cmd_valid) begin
                op_q      <= i_cmd_op;
                has_arg_q <= i_cmd_has_arg;
                arg_q     <= i_cmd_arg;
                nresp_q   <= i_cmd_nresp;
            end else if (state == ST_SEND_ARG && o_wr) begin
                arg_q <= {arg_q[DATA_SZ-N-1:0], {N{1'b0}}};
            end

            if (state != ST_SEND_ARG)
                byte_idx <= '0;
            else if (o_wr)
                byte_idx <= byte_idx + 1'b1;

            if (!in_recv)
                word_cnt <= '0;
            else if (word_done)
                word_cnt <= word_cnt + 1'b1;

            if (!in_recv || pop)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    debug_word_packer #(
        .N       (N),
        .DATA_SZ (DATA_SZ)
    ) u_packer (
        .clk        (i_clk),
        .rst_n      (i_reset),
        .clear      (!in_recv),
        .push       (pop),
        .rx_byte    (i_rx_data),
        .word_done  (word_done),
        .resp_data  (o_resp_data),
        .resp_valid (o_resp_valid)
    );

endmodule

// File: tb/tb_debug_host_master.sv
// Bench for debug_host_master: scoreboard queues of expected TX bytes and response
// words, with an RX FIFO model and optional TX-full / RX-gap randomisation.
module tb_debug_host_master;
    import debug_pkg::*;

    localparam int TO = 100;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [7:0]  i_cmd_op;
    logic        i_cmd_has_arg;
    logic [31:0] i_cmd_arg;
    logic [7:0]  i_cmd_nresp;
    logic [7:0]  o_tx_data;
    logic        o_wr;
    logic        i_tx_full;
    logic [7:0]  i_rx_data;
    logic        i_rx_empty;
    logic        o_rd;
    logic [31:0] o_resp_data;
    logic        o_resp_valid;
    logic        o_done;
    logic        o_timeout;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_resp[$];
    logic [7:0]  rx_pend[$];
    logic [7:0]  rx_fifo[$];
    int          wr_cyc[$];
    int          done_cnt = 0, done_cyc = 0, to_seen = 0, to_cyc = 0;
    int          resp_cnt = 0, resp_cyc = 0, acc_cyc = 0, pop_cyc = 0;
    bit          rd_seen = 0, tx_toggle = 0, rx_gap = 0;

    debug_host_master #(.N(8), .DATA_SZ(32), .CNT_W(8), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_has_arg(i_cmd_has_arg), .i_cmd_arg(i_cmd_arg), .i_cmd_nresp(i_cmd_nresp),
        .o_tx_data(o_tx_data), .o_wr(o_wr), .i_tx_full(i_tx_full),
        .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rd(o_rd),
        .o_resp_data(o_resp_data), .o_resp_valid(o_resp_valid),
        .o_done(o_done), .o_timeout(o_timeout), .o_busy(o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    task automatic monitor();
        logic [7:0]  e8;
        logic [31:0] e32;
        forever begin
            @(negedge i_clk);
            rd_seen = o_rd && !i_rx_empty;
            if (rd_seen) pop_cyc = cyc;
            if (i_cmd_valid && o_cmd_ready) acc_cyc = cyc;
            if (o_wr) begin
                wr_cyc.push_back(cyc);
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got unexpected %02h, required no write", o_tx_data);
                end else begin
                    e8 = exp_tx.pop_front();
                    if (o_tx_data !== e8) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h required %02h", o_tx_data, e8);
                    end
                end
                checks++;
                if (o_rd !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_rd_overlap: o_rd=%b required 0 while writing", o_rd);
                end
            end
            if (o_resp_valid) begin
                resp_cnt++;
                resp_cyc = cyc;
                checks++;
                if (exp_resp.size() == 0) begin
                    errors++;
                    $display("FAIL resp_word: got unexpected %08h, required none", o_resp_data);
                end else begin
                    e32 = exp_resp.pop_front();
                    if (o_resp_data !== e32) begin
                        errors++;
                        $display("FAIL resp_word: got %08h required %08h", o_resp_data, e32);
                    end
                end
            end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_timeout) begin to_seen++; to_cyc = cyc; end
        end
    endtask

    task automatic driver();
        forever begin
            @(posedge i_clk);
            cyc++;
            #1;
            if (rd_seen && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
            if (rx_pend.size() > 0 && (!rx_gap || $urandom_range(0, 3) == 0))
                rx_fifo.push_back(rx_pend.pop_front());
            i_rx_empty = (rx_fifo.size() == 0);
            i_rx_data  = i_rx_empty ? 8'h00 : rx_fifo[0];
            i_tx_full  = tx_toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input bit has, input logic [31:0] arg,
                            input logic [7:0] nr);
        int n = 0;
        exp_tx.push_back(op);
        if (has) for (int i = 0; i < 4; i++) exp_tx.push_back(arg[31-8*i -: 8]);
        @(posedge i_clk); #1;
        i_cmd_op = op; i_cmd_has_arg = has; i_cmd_arg = arg; i_cmd_nresp = nr;
        i_cmd_valid = 1'b1;
        @(negedge i_clk);
        while (!o_cmd_ready && n < 200) begin n++; @(negedge i_clk); end
        checks++;
        if (!o_cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: ready=%b required 1 within 200 cycles", o_cmd_ready);
        end
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        @(negedge i_clk);
        while (o_busy && n < budget) begin n++; @(negedge i_clk); end
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL %s_idle: busy=%b required 0 within %0d cycles", name, o_busy, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_cmd_ready, o_busy, o_wr, o_rd, o_resp_valid, o_done, o_timeout} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 1000000",
                     {o_cmd_ready, o_busy, o_wr, o_rd, o_resp_valid, o_done, o_timeout});
        end
        checks++;
        if (o_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %08h required 00000000", o_resp_data);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_cmd_ready, o_busy} !== 2'b10) begin
            errors++;
            $display("FAIL post_release: ready/busy=%b required 10", {o_cmd_ready, o_busy});
        end
    endtask

    task automatic test_load_inst();
        int d0 = done_cnt;
        wr_cyc.delete();
        send_cmd(OP_LOAD_INST, 1'b1, 32'h8C220004, 8'd0);
        wait_idle(50, "load");
        checks++;
        if (wr_cyc.size() != 5) begin
            errors++;
            $display("FAIL load_wr_count: got %0d required 5", wr_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_cyc[i] != acc_cyc + 1 + i) begin
                    errors++;
                    $display("FAIL load_wr_cycle: byte %0d at +%0d required +%0d", i, wr_cyc[i] - acc_cyc, i + 1);
                end
            end
        end
        checks++;
        if (done_cnt != d0 + 1 || done_cyc != acc_cyc + 6) begin
            errors++;
            $display("FAIL load_done: count %0d at +%0d required 1 at +6", done_cnt - d0, done_cyc - acc_cyc);
        end
    endtask

    task automatic test_step_noarg();
        int d0 = done_cnt;
        send_cmd(OP_STEP, 1'b0, 32'h0, 8'd0);
        wait_idle(20, "step");
        checks++;
        if (done_cnt != d0 + 1 || done_cyc != acc_cyc + 2) begin
            errors++;
            $display("FAIL step_done: count %0d at +%0d required 1 at +2", done_cnt - d0, done_cyc - acc_cyc);
        end
    endtask

    task automatic test_read_pc(input logic [31:0] w, input string name);
        int d0 = done_cnt, r0 = resp_cnt;
        exp_resp.push_back(w);
        send_cmd(OP_READ_PC, 1'b0, 32'h0, 8'd1);
        for (int i = 0; i < 4; i++) rx_pend.push_back(w[31-8*i -: 8]);
        wait_idle(100, name);
        checks++;
        if (resp_cnt != r0 + 1 || done_cnt != d0 + 1 || done_cyc != resp_cyc + 1) begin
            errors++;
            $display("FAIL %s_done: words %0d done %0d gap %0d required 1 1 1",
                     name, resp_cnt - r0, done_cnt - d0, done_cyc - resp_cyc);
        end
    endtask

    task automatic test_read_regs();
        logic [31:0] words[32];
        int d0 = done_cnt, r0 = resp_cnt;
        tx_toggle = 1; rx_gap = 1;
        for (int i = 0; i < 32; i++) begin
            words[i] = $urandom();
            exp_resp.push_back(words[i]);
        end
        send_cmd(OP_READ_REGS, 1'b0, 32'h0, 8'd32);
        for (int i = 0; i < 32; i++)
            for (int b = 0; b < 4; b++) rx_pend.push_back(words[i][31-8*b -: 8]);
        wait_idle(3000, "regs");
        tx_toggle = 0; rx_gap = 0;
        checks++;
        if (resp_cnt != r0 + 32 || done_cnt != d0 + 1 || exp_resp.size() != 0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL regs_total: words %0d done %0d left %0d/%0d required 32 1 0/0",
                     resp_cnt - r0, done_cnt - d0, exp_resp.size(), exp_tx.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] bytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int d0 = done_cnt, t0 = to_seen, r0 = resp_cnt;
        exp_resp.push_back(32'h11223344);
        send_cmd(OP_READ_MEM, 1'b0, 32'h0, 8'd2);
        for (int i = 0; i < 5; i++) rx_pend.push_back(bytes[i]);
        wait_idle(TO + 200, "timeout");
        checks++;
        if (to_seen != t0 + 1 || to_cyc - pop_cyc != TO) begin
            errors++;
            $display("FAIL timeout_pulse: count %0d delay %0d required 1 %0d", to_seen - t0, to_cyc - pop_cyc, TO);
        end
        checks++;
        if (done_cnt != d0 || resp_cnt != r0 + 1 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_state: done %0d words %0d ready %b required 0 1 1",
                     done_cnt - d0, resp_cnt - r0, o_cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        send_cmd(OP_LOAD_INST, 1'b1, 32'hA1B2C3D4, 8'd0);
        repeat (3) begin @(posedge i_clk); #1; end
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_cmd_ready, o_busy, o_wr, o_rd, o_resp_valid, o_done, o_timeout} !== 7'b1000000
            || o_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_out: ctrl %b data %08h required 1000000 00000000",
                     {o_cmd_ready, o_busy, o_wr, o_rd, o_resp_valid, o_done, o_timeout}, o_resp_data);
        end
        checks++;
        if (exp_tx.size() != 2) begin
            errors++;
            $display("FAIL midreset_sent: %0d bytes unsent required 2", exp_tx.size());
        end
        exp_tx.delete();
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        d0 = done_cnt;
        send_cmd(OP_LOAD_INST, 1'b1, 32'h01020304, 8'd0);
        wait_idle(50, "fresh");
        checks++;
        if (done_cnt != d0 + 1 || done_cyc != acc_cyc + 6 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL fresh_cmd: done %0d at +%0d left %0d required 1 at +6 left 0",
                     done_cnt - d0, done_cyc - acc_cyc, exp_tx.size());
        end
    endtask

    task automatic test_stray_drain();
        int r0 = resp_cnt;
        rx_pend.push_back(8'hAA); rx_pend.push_back(8'hBB); rx_pend.push_back(8'hCC);
        repeat (10) @(negedge i_clk);
        checks++;
        if (rx_fifo.size() != 0 || rx_pend.size() != 0 || resp_cnt != r0) begin
            errors++;
            $display("FAIL stray_drain: fifo %0d pend %0d words %0d required 0 0 0",
                     rx_fifo.size(), rx_pend.size(), resp_cnt - r0);
        end
        test_read_pc(32'hDEADBEEF, "stray_pc");
    endtask

    initial begin
        i_reset = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_op = 8'h00; i_cmd_has_arg = 1'b0;
        i_cmd_arg = 32'h0; i_cmd_nresp = 8'h00;
        i_tx_full = 1'b0; i_rx_empty = 1'b1; i_rx_data = 8'h00;
        fork
            monitor();
            driver();
        join_none
        test_reset();
        test_load_inst();
        test_step_noarg();
        test_read_pc(32'h0000002C, "read_pc");
        test_read_regs();
        test_timeout();
        test_reset_mid();
        test_stray_drain();
        checks++;
        if (exp_tx.size() != 0 || exp_resp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: tx %0d resp %0d left, required 0 0", exp_tx.size(), exp_resp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
